// File: rtl/parity_frame_checker.sv
// parity_frame_checker
// XOR-reduces a frame of WIDTH-bit words that arrive over a valid/ready
// stream. When a frame closes, it presents the frame parity, the word count
// and an error flag. The error flag is set on a mismatch with the received
// parity bit, or when the frame was cut off at MAX_WORDS. A saturating
// counter keeps a running total of errored frames. Reset is synchronous and
// active-low.
module parity_frame_checker #(
    parameter int  WIDTH     = 4,
    parameter int  MAX_WORDS = 16,
    parameter int  ODD       = 0,
    parameter int  CNT_W     = 16,
    localparam int LEN_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_error,
    output logic             out_overflow,
    output logic [LEN_W-1:0] out_len,
    output logic [CNT_W-1:0] err_count
);

    // ACCUM takes words; RESULT holds a closed frame until it is taken.
    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
    localparam logic             ODD_BIT = (ODD != 0);

    state_t           state;
    state_t           state_next;
    logic             acc;
    logic             acc_next;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_next;
    logic [LEN_W-1:0] cnt_inc;
    logic             word_par;
    logic             close;
    logic             frame_par;
    logic             frame_ovf;
    logic             frame_err;

    // Parity of the current word, and the length of the frame if this beat
    // ends it.
    assign word_par = ^in_data;
    assign cnt_inc  = cnt + LEN_W'(1);

    // Close values are based on the beat being accepted now. They only
    // matter on the edge where close is high.
    assign frame_par = acc ^ word_par ^ ODD_BIT;
    assign frame_ovf = ~in_last;
    assign frame_err = (frame_par != in_par) | frame_ovf;

    // Next-state, handshake and accumulator logic.
    // NOTE: every signal gets a default before the case statement so that no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        in_ready   = 1'b0;
        close      = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_last || (cnt_inc == MAX_LEN)) begin
                        close      = 1'b1;
                        acc_next   = 1'b0;
                        cnt_next   = '0;
                        state_next = RESULT;
                    end else begin
                        acc_next = acc ^ word_par;
                        cnt_next = cnt_inc;
                    end
                end
            end
            RESULT: begin
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // State and running accumulator. A reset in the middle of a frame
    // discards the partial frame.
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values, whatever the block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ACCUM;
            acc   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
        end
    end

    // Result register: loaded on close, held while it is stalled, and
    // retired on out_ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid    <= 1'b0;
            out_parity   <= 1'b0;
            out_error    <= 1'b0;
            out_overflow <= 1'b0;
            out_len      <= '0;
        end else if (close) begin
            out_valid    <= 1'b1;
            out_parity   <= frame_par;
            out_error    <= frame_err;
            out_overflow <= frame_ovf;
            out_len      <= cnt_inc;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Errored-frame counter. It saturates at all-ones and only reset
    // clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_count <= '0;
        end else if (close && frame_err && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule
